fir8_coef_axil_regs: RTL and testbench

//  AXI4-Lite slave register bank for the 8-tap, 14-bit FIR peripheral. It holds the control bits and
//  the coefficients, and drives the coefficients into the FIR datapath. Coefficients are double-buffered:

---
 rtl/fir8_coef_axil_regs_pkg.sv | 32 +++
 rtl/fir8_coef_axil_regs_if.sv | 37 +++
 rtl/fir8_coef_axil_regs_bank.sv | 58 +++++
 rtl/fir8_coef_axil_regs.sv | 179 +++++++++++++++++
 tb/tb_fir8_coef_axil_regs.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir8_coef_axil_regs_pkg.sv
// fir8_regs_pkg: shared constants and types for the FIR coefficient register bank.
//   - register byte addresses and their word indices
//   - AXI response codes
//   - coefficient scalar/array types and a sign-extension helper
package fir8_regs_pkg;

  localparam int N_TAPS = 8;
  localparam int COEF_W = 14;
  localparam int TAP_W  = $clog2(N_TAPS);

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_COEF0  = 6'h08;
  localparam logic [5:0] ADDR_ID     = 6'h28;

  // Decode works on word indices; the two byte-lane bits are ignored.
  localparam logic [3:0] IDX_CTRL   = ADDR_CTRL[5:2];
  localparam logic [3:0] IDX_STATUS = ADDR_STATUS[5:2];
  localparam logic [3:0] IDX_COEF0  = ADDR_COEF0[5:2];
  localparam logic [3:0] IDX_ID     = ADDR_ID[5:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t coef_arr_t [N_TAPS];

  function automatic logic [31:0] sext32(input coef_t c);
    return {{(32 - COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/fir8_coef_axil_regs_if.sv
// fir8_coef_axil_regs_if: AXI4-Lite signal bundle.
//   master modport drives AW/W/AR payload+valid and B/R ready;
//   slave modport drives AW/W/AR ready and B/R response+valid.
interface fir8_coef_axil_regs_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fir8_coef_axil_regs_bank.sv
// fir8_coef_bank: double-buffered coefficient storage.
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en/wr_idx/wr_data  shadow coefficient write port
//   commit_req            request to copy shadow -> active on a later sample strobe
//   sample_valid          FIR sample strobe (commit point)
//   coef_active           coefficients seen by the filter
//   shadow                software-visible coefficients
//   pending               a commit is waiting for a strobe
module fir8_coef_bank
  import fir8_regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [TAP_W-1:0] wr_idx,
  input  coef_t            wr_data,
  input  logic             commit_req,
  input  logic             sample_valid,
  output coef_arr_t        coef_active,
  output coef_arr_t        shadow,
  output logic             pending
);

  coef_arr_t shadow_reg;
  coef_arr_t active_reg;
  logic      pending_reg;

  // Only a request already registered as pending can commit, so a strobe in
  // the same cycle as the COMMIT write is ignored. Extra requests while
  // pending are absorbed into the outstanding one.
  logic commit_now;
  assign commit_now = pending_reg && sample_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      pending_reg <= pending_reg ? !sample_valid : commit_req;
      for (int i = 0; i < N_TAPS; i++) begin
        if (wr_en && (wr_idx == TAP_W'(i)))
          shadow_reg[i] <= wr_data;
        // Copies the registered shadow, so a same-cycle shadow write lands
        // only in the next commit.
        if (commit_now)
          active_reg[i] <= shadow_reg[i];
      end
    end
  end

  assign coef_active = active_reg;
  assign shadow      = shadow_reg;
  assign pending     = pending_reg;

endmodule

// File: rtl/fir8_coef_axil_regs.sv
// fir8_coef_axil_regs: AXI4-Lite register bank for the 8-tap FIR.
//   s00_axi_aclk     single clock
//   s00_axi_aresetn  synchronous active-low reset
//   s00_axi          AXI4-Lite slave port (interface)
//   sample_valid     FIR sample strobe, commit point for coefficients
//   fir_ovf          saturation pulse, sets sticky STATUS.OVF
//   coef_active      active coefficients, tap k at [k*COEF_W +: COEF_W]
//   fir_enable       CTRL.EN
//   fir_bypass       CTRL.BYP
module fir8_coef_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          N_TAPS             = 8,
  parameter int          COEF_W             = 14,
  parameter logic [31:0] ID_VALUE           = 32'hF1A8_0E14
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_aresetn,
  fir8_coef_axil_regs_if.slave       s00_axi,
  input  logic                       sample_valid,
  input  logic                       fir_ovf,
  output logic [N_TAPS*COEF_W-1:0]   coef_active,
  output logic                       fir_enable,
  output logic                       fir_bypass
);
  import fir8_regs_pkg::*;

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic             aw_held_reg, w_held_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic [COEF_W-1:0] w_data_reg;  // no register uses wdata above the coefficient width
  logic [1:0]       w_strb_reg;
  logic             bvalid_reg, rvalid_reg;
  logic [1:0]       bresp_reg, rresp_reg;
  logic [31:0]      rdata_reg;
  logic             en_reg, byp_reg, ovf_reg;

  coef_arr_t shadow, active;
  logic      pending;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write;

  // Readies are gated by reset so every output is low while reset is held.
  assign s00_axi.awready = s00_axi_aresetn && !aw_held_reg && !bvalid_reg;
  assign s00_axi.wready  = s00_axi_aresetn && !w_held_reg && !bvalid_reg;
  assign s00_axi.arready = s00_axi_aresetn && !rvalid_reg;

  assign aw_hs    = s00_axi.awvalid && s00_axi.awready;
  assign w_hs     = s00_axi.wvalid && s00_axi.wready;
  assign b_hs     = bvalid_reg && s00_axi.bready;
  assign ar_hs    = s00_axi.arvalid && s00_axi.arready;
  assign r_hs     = rvalid_reg && s00_axi.rready;
  assign do_write = aw_held_reg && w_held_reg;

  // Write decode and byte-lane merge for coefficients.
  logic [IDX_W-1:0] coef_off;
  logic             wr_ctrl, wr_status, wr_coef, wr_ok;
  coef_t            coef_new;
  always_comb begin
    coef_off  = aw_idx_reg - IDX_COEF0;
    wr_ctrl   = (aw_idx_reg == IDX_CTRL);
    wr_status = (aw_idx_reg == IDX_STATUS);
    wr_coef   = (aw_idx_reg >= IDX_COEF0) && (coef_off < IDX_W'(N_TAPS));
    wr_ok     = wr_ctrl || wr_status || wr_coef;
    coef_new  = shadow[coef_off[TAP_W-1:0]];
    if (w_strb_reg[0]) coef_new[7:0]        = w_data_reg[7:0];
    if (w_strb_reg[1]) coef_new[COEF_W-1:8] = w_data_reg[COEF_W-1:8];
  end

  logic ctrl_byte0, commit_req, ovf_clr;
  assign ctrl_byte0 = do_write && wr_ctrl && w_strb_reg[0];
  assign commit_req = ctrl_byte0 && w_data_reg[2];
  assign ovf_clr    = do_write && wr_status && w_strb_reg[0] && w_data_reg[1];

  // Read decode, evaluated against the current (pre-write) register state.
  logic [IDX_W-1:0] ar_idx, rd_off;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp;
  always_comb begin
    ar_idx  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_off  = ar_idx - IDX_COEF0;
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_idx == IDX_CTRL)
      rd_data = {30'd0, byp_reg, en_reg};
    else if (ar_idx == IDX_STATUS)
      rd_data = {30'd0, ovf_reg, pending};
    else if ((ar_idx >= IDX_COEF0) && (rd_off < IDX_W'(N_TAPS)))
      rd_data = sext32(shadow[rd_off[TAP_W-1:0]]);
    else if (ar_idx == IDX_ID)
      rd_data = ID_VALUE;
    else
      rd_resp = RESP_SLVERR;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
      en_reg      <= 1'b0;
      byp_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        w_data_reg <= s00_axi.wdata[COEF_W-1:0];
        w_strb_reg <= s00_axi.wstrb[1:0];
      end
      if (do_write) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (ctrl_byte0) begin
          en_reg  <= w_data_reg[0];
          byp_reg <= w_data_reg[1];
        end
      end else if (b_hs) begin
        bvalid_reg <= 1'b0;
      end
      // A saturation pulse beats a same-cycle W1C.
      ovf_reg <= fir_ovf || (ovf_reg && !ovf_clr);
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
        rresp_reg  <= rd_resp;
      end else if (r_hs) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  fir8_coef_bank u_bank (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .wr_en        (do_write && wr_coef),
    .wr_idx       (coef_off[TAP_W-1:0]),
    .wr_data      (coef_new),
    .commit_req   (commit_req),
    .sample_valid (sample_valid),
    .coef_active  (active),
    .shadow       (shadow),
    .pending      (pending)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_flat
      assign coef_active[gi*COEF_W +: COEF_W] = active[gi];
    end
  endgenerate

  assign s00_axi.bvalid = bvalid_reg;
  assign s00_axi.bresp  = bresp_reg;
  assign s00_axi.rvalid = rvalid_reg;
  assign s00_axi.rdata  = rdata_reg;
  assign s00_axi.rresp  = rresp_reg;
  assign fir_enable     = en_reg;
  assign fir_bypass     = byp_reg;

  // Bus fields this register map never looks at.
  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0],
                         s00_axi.wdata[C_S_AXI_DATA_WIDTH-1:COEF_W], s00_axi.wstrb[3:2]};

endmodule

// File: tb/tb_fir8_coef_axil_regs.sv
module tb_fir8_coef_axil_regs;
  localparam int NT = 8;
  localparam int CW = 14;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic sample_valid = 1'b0;
  logic fir_ovf = 1'b0;
  logic [NT*CW-1:0] coef_active;
  logic fir_enable, fir_bypass;

  fir8_coef_axil_regs_if #(.ADDR_W(6), .DATA_W(32)) axi ();

  fir8_coef_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi         (axi),
    .sample_valid    (sample_valid),
    .fir_ovf         (fir_ovf),
    .coef_active     (coef_active),
    .fir_enable      (fir_enable),
    .fir_bypass      (fir_bypass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [CW-1:0] exp_shadow[NT];
  logic [CW-1:0] exp_active[NT];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NT*CW-1:0] pack_active();
    logic [NT*CW-1:0] v;
    for (int k = 0; k < NT; k++) v[k*CW +: CW] = exp_active[k];
    return v;
  endfunction

  task automatic wait_b();
    int n = 0;
    check("b_latency", axi.bvalid, 1'b1);
    axi.bready = 1'b1;
    while (!axi.bvalid && n < 20) begin tick(); n++; end
    if (!axi.bvalid) begin
      timeout("bvalid");
      void'(b_q.pop_front());
    end else begin
      check("bresp", axi.bresp, b_q.pop_front());
      tick();
      check("bvalid_clear", axi.bvalid, 1'b0);
    end
    axi.bready = 1'b0;
  endtask

  // sv_upd/ovf_upd drive sample_valid/fir_ovf in the register-update cycle.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input logic sv_upd, input logic ovf_upd);
    int n = 0;
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    b_q.push_back(resp);
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 40) begin
      aw_now = axi.awvalid && axi.awready;
      w_now  = axi.wvalid && axi.wready;
      tick(); n++;
      if (aw_now) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin axi.wvalid = 1'b0;  w_done = 1;  end
    end
    if (!(aw_done && w_done)) begin
      timeout($sformatf("write_accept_%0h", addr));
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      void'(b_q.pop_front());
      return;
    end
    sample_valid = sv_upd; fir_ovf = ovf_upd;
    tick();
    sample_valid = 1'b0; fir_ovf = 1'b0;
    wait_b();
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    r_q.push_back({exp_resp, exp_data});
    axi.araddr = addr; axi.arvalid = 1'b1;
    while (!axi.arready && n < 20) begin tick(); n++; end
    if (!axi.arready) begin
      timeout($sformatf("arready_%0h", addr));
      axi.arvalid = 1'b0;
      void'(r_q.pop_front());
      return;
    end
    tick();
    axi.arvalid = 1'b0;
    check($sformatf("r_latency_%0h", addr), axi.rvalid, 1'b1);
    axi.rready = 1'b1;
    check($sformatf("read_%0h", addr), {axi.rresp, axi.rdata}, r_q.pop_front());
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic strobe();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int k = 0; k < NT; k++) begin exp_shadow[k] = '0; exp_active[k] = '0; end

    // Reset state
    repeat (3) tick();
    check("rst_outputs", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                          axi.bresp, axi.rresp, axi.rdata, fir_enable, fir_bypass}, '0);
    check("rst_coef", coef_active, '0);
    aresetn = 1'b1;
    tick();

    // 1: reset read-back
    axi_read(6'h00, 32'h0, OKAY);
    axi_read(6'h04, 32'h0, OKAY);
    axi_read(6'h08, 32'h0, OKAY);
    axi_read(6'h28, 32'hF1A8_0E14, OKAY);

    // 2: load 1..8, commit, wait with no strobe, then strobe
    for (int k = 0; k < NT; k++) begin
      axi_write(6'(8 + 4*k), 32'(k + 1), 4'hF, OKAY, 1'b0, 1'b0);
      exp_shadow[k] = CW'(k + 1);
    end
    axi_write(6'h00, 32'h4, 4'hF, OKAY, 1'b0, 1'b0);
    repeat (20) tick();
    check("no_commit_without_strobe", coef_active, pack_active());
    axi_read(6'h04, 32'h1, OKAY);
    strobe();
    for (int k = 0; k < NT; k++) exp_active[k] = exp_shadow[k];
    check("commit_taps_1_to_8", coef_active, pack_active());
    axi_read(6'h04, 32'h0, OKAY);

    axi_write(6'h00, 32'h3, 4'hF, OKAY, 1'b0, 1'b0);
    check("en_byp_on", {fir_enable, fir_bypass}, 2'b11);
    axi_read(6'h00, 32'h3, OKAY);
    axi_write(6'h00, 32'h1, 4'hF, OKAY, 1'b0, 1'b0);
    check("byp_off", {fir_enable, fir_bypass}, 2'b10);

    // 3: negative coefficient
    axi_write(6'h14, 32'h0000_3FFF, 4'hF, OKAY, 1'b0, 1'b0);
    exp_shadow[3] = 14'h3FFF;
    axi_read(6'h14, 32'hFFFF_FFFF, OKAY);
    axi_write(6'h00, 32'h5, 4'hF, OKAY, 1'b0, 1'b0);
    strobe();
    for (int k = 0; k < NT; k++) exp_active[k] = exp_shadow[k];
    check("tap3_minus1", coef_active[3*CW +: CW], 14'h3FFF);
    check("commit_all_taps", coef_active, pack_active());

    // 4: AW three cycles ahead of W, B held off for five cycles
    b_q.push_back(OKAY);
    axi.awaddr = 6'h1C; axi.awvalid = 1'b1;
    check("awready_idle", axi.awready, 1'b1);
    tick();
    axi.awvalid = 1'b0;
    repeat (3) begin
      check("aw_held_ready", {axi.awready, axi.wready}, 2'b01);
      tick();
    end
    axi.wdata = 32'h155; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("both_held_ready", {axi.bvalid, axi.awready, axi.wready}, 3'b000);
    tick();
    repeat (5) begin
      check("b_stall", {axi.bvalid, axi.awready, axi.wready}, 3'b100);
      tick();
    end
    wait_b();
    check("ready_after_b", {axi.awready, axi.wready}, 2'b11);
    exp_shadow[5] = 14'h0155;
    axi_read(6'h1C, 32'h155, OKAY);

    // Byte strobe: only byte 1 updates
    axi_write(6'h1C, 32'h0000_3A00, 4'b0010, OKAY, 1'b0, 1'b0);
    exp_shadow[5] = 14'h3A55;
    axi_read(6'h1C, 32'hFFFF_FA55, OKAY);

    // 5: unmapped and read-only targets
    axi_write(6'h30, 32'hFFFF_FFFF, 4'hF, SLVERR, 1'b0, 1'b0);
    axi_write(6'h28, 32'h0, 4'hF, SLVERR, 1'b0, 1'b0);
    axi_read(6'h00, 32'h1, OKAY);
    axi_read(6'h08, 32'h1, OKAY);
    axi_read(6'h28, 32'hF1A8_0E14, OKAY);
    axi_read(6'h3C, 32'h0, SLVERR);
    axi_read(6'h2C, 32'h0, SLVERR);
    check("slverr_no_commit", coef_active, pack_active());

    // 6: OVF set beats same-cycle W1C; lone W1C clears
    axi_write(6'h04, 32'h2, 4'hF, OKAY, 1'b0, 1'b1);
    axi_read(6'h04, 32'h2, OKAY);
    axi_write(6'h04, 32'h2, 4'hF, OKAY, 1'b0, 1'b0);
    axi_read(6'h04, 32'h0, OKAY);

    // COMMIT coinciding with a strobe waits for the next strobe
    axi_write(6'h08, 32'h123, 4'hF, OKAY, 1'b0, 1'b0);
    exp_shadow[0] = 14'h0123;
    axi_write(6'h00, 32'h5, 4'hF, OKAY, 1'b1, 1'b0);
    check("same_cycle_strobe_no_commit", coef_active, pack_active());
    axi_read(6'h04, 32'h1, OKAY);
    strobe();
    for (int k = 0; k < NT; k++) exp_active[k] = exp_shadow[k];
    check("next_strobe_commits", coef_active, pack_active());
    axi_read(6'h04, 32'h0, OKAY);

    // Reset while a read response is outstanding
    axi.araddr = 6'h00; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    check("r_outstanding", axi.rvalid, 1'b1);
    aresetn = 1'b0;
    tick();
    check("mid_reset_drop", {axi.rvalid, axi.bvalid, fir_enable, axi.arready}, 4'b0000);
    check("mid_reset_coef", coef_active, '0);
    aresetn = 1'b1;
    tick();
    check("post_reset_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
